// File: rtl/lc3_mem_pkg.sv
// Shared memory-stage definitions for the LC-3 datapath.
// The control unit uses the same wait-count defaults when it waits on Done.
package lc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_REC = 3'd4,
    ST_IO     = 3'd5,
    ST_DONE   = 3'd6
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned WR_WAIT_DEF = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned SRAM_AW     = 20;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; times the SRAM strobe dwell.
module mem_wait_counter
  import lc3_mem_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Turns one-cycle read/write requests into timed active-low SRAM strobes,
// with a memory-mapped switch/hex-display port at IO_ADDR.
module sram_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT = WR_WAIT_DEF,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Req_Rd,
  input  logic               Req_Wr,
  input  logic [DATA_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  Wdata,
  input  logic [DATA_W-1:0]  Switches,
  output logic [DATA_W-1:0]  Rdata,
  output logic               Done,
  output logic               Busy,
  output logic [DATA_W-1:0]  Hex_Out,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0]  SRAM_DQ_Out,
  output logic               SRAM_DQ_Oe,
  input  logic [DATA_W-1:0]  SRAM_DQ_In,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  mem_state_t       state_q, state_d;
  logic             wr_q;
  logic             accept_c;
  logic             cnt_zero_c;
  logic             cnt_dec_c;
  logic [CNT_W-1:0] cnt_load_val_c;
  logic             ce_n_d, oe_n_d, we_n_d, dq_oe_d, done_d, busy_d;

  assign accept_c       = (state_q == ST_IDLE) && (Req_Rd || Req_Wr);
  assign cnt_load_val_c = Req_Wr ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
  assign cnt_dec_c      = (state_q == ST_RD) || (state_q == ST_WR);

  mem_wait_counter u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (accept_c),
    .load_val (cnt_load_val_c),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; write wins when both requests arrive together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Req_Rd || Req_Wr) begin
          if (Addr == IO_ADDR) state_d = ST_IO;
          else if (Req_Wr)     state_d = ST_WR;
          else                 state_d = ST_RD;
        end
      end
      ST_RD:     if (cnt_zero_c) state_d = ST_RD_CAP;
      ST_RD_CAP: state_d = ST_DONE;
      ST_WR:     if (cnt_zero_c) state_d = ST_WR_REC;
      ST_WR_REC: state_d = ST_DONE;
      ST_IO:     state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobe values are decoded from the next state so the registers align with it.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_d)
      ST_RD, ST_RD_CAP: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      ST_WR: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      ST_WR_REC: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      SRAM_CE_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_DQ_Oe <= 1'b0;
      Done       <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      SRAM_CE_N  <= ce_n_d;
      SRAM_UB_N  <= ce_n_d;
      SRAM_LB_N  <= ce_n_d;
      SRAM_OE_N  <= oe_n_d;
      SRAM_WE_N  <= we_n_d;
      SRAM_DQ_Oe <= dq_oe_d;
      Done       <= done_d;
      Busy       <= busy_d;
    end
  end

  // Request latches and data capture; SRAM_DQ_Out doubles as the latched Wdata.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q        <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_Out <= '0;
      Rdata       <= '0;
      Hex_Out     <= '0;
    end else begin
      if (accept_c) begin
        wr_q        <= Req_Wr;
        SRAM_ADDR   <= {4'b0000, Addr};
        SRAM_DQ_Out <= Wdata;
      end
      if (state_q == ST_RD_CAP) Rdata <= SRAM_DQ_In;
      if (state_q == ST_IO) begin
        if (wr_q) Hex_Out <= SRAM_DQ_Out;
        else      Rdata   <= Switches;
      end
    end
  end

endmodule
